// File: rtl/key_search_collector_pkg.sv
// Shared constants for the key search collector: FSM encoding, parameter defaults, LED map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ksa_pkg;

  // Default geometry of the cracker array.
  localparam int NUM_CORES_DEF = 4;
  localparam int KEY_W_DEF     = 24;

  // FSM state set (kept as plain 2-bit constants for legacy tools).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_FOUND  = 2'd2;
  localparam logic [1:0] ST_FAIL   = 2'd3;

  // Board LED bit positions.
  localparam int LED_W      = 10;
  localparam int LED_FOUND  = 0;
  localparam int LED_FAIL   = 1;
  localparam int LED_SEARCH = 2;
  localparam int LED_CORE0  = 6;

  // Width of a core index; never zero so a single-core build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_search_collector_if.sv
// Core-side and result-side signal bundle between the cracker array and the collector.
// Latency: n/a (wiring only).
// Backpressure: result side is valid/ack; the core side has none, stop_all is the only feedback.
interface key_search_collector_if
  import ksa_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int KEY_W     = KEY_W_DEF
);
  localparam int IDX_W = idx_width(NUM_CORES);

  logic [NUM_CORES-1:0]       core_found;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic                       stop_all;
  logic                       result_valid;
  logic                       result_ack;
  logic [KEY_W-1:0]           result_key;
  logic [IDX_W-1:0]           result_core;

  // Environment side: cores plus the downstream result consumer.
  modport master (
    output core_found, core_done, core_key, result_ack,
    input  stop_all, result_valid, result_key, result_core
  );

  // Collector side.
  modport slave (
    input  core_found, core_done, core_key, result_ack,
    output stop_all, result_valid, result_key, result_core
  );
endinterface

// File: rtl/key_search_collector_prio_enc.sv
// Lowest-index-wins priority encoder over the per-core found pulses.
// Latency: purely combinational.
// Backpressure: none.
module core_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest asserted index overwrites last and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/key_search_collector.sv
// Watches N cracker cores, latches the first winning key (or total failure) and halts the array.
// Latency: result/stop_all/LEDR registered, visible the cycle after the deciding edge.
// Backpressure: result held stable until result_ack; no new campaign accepted until then.
module key_search_collector
  import ksa_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int KEY_W     = KEY_W_DEF
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  key_search_collector_if.slave  bus,
  output logic [31:0]            elapsed,
  output logic [LED_W-1:0]       LEDR
);

  localparam int IDX_W = idx_width(NUM_CORES);

  logic [1:0]           state;
  logic [NUM_CORES-1:0] done_mask;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic                 all_done;
  logic [LED_W-1:0]     led_found;
  logic [KEY_W-1:0]     core_keys [NUM_CORES];

  core_prio_enc #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req (bus.core_found),
    .idx (win_idx),
    .any (win_any)
  );

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_slice
    assign core_keys[g] = bus.core_key[g*KEY_W +: KEY_W];
  end

  // A core that finished earlier or finishes this cycle both count toward exhaustion.
  assign all_done = &(done_mask | bus.core_done);

  // LED image shown while FOUND: found lamp plus the lamp of the winning core.
  always_comb begin
    led_found            = '0;
    led_found[LED_FOUND] = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((LED_CORE0 + i < LED_W) && (win_idx == IDX_W'(i))) led_found[LED_CORE0 + i] = 1'b1;
    end
  end

  // Campaign FSM; every output is a flop so nothing combinational reaches the pins.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      done_mask        <= '0;
      elapsed          <= '0;
      LEDR             <= '0;
      bus.stop_all     <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_key   <= '0;
      bus.result_core  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_SEARCH;
            done_mask        <= '0;
            elapsed          <= '0;
            LEDR             <= '0;
            LEDR[LED_SEARCH] <= 1'b1;
          end
        end
        ST_SEARCH: begin
          done_mask <= done_mask | bus.core_done;
          if (elapsed != 32'hFFFF_FFFF) elapsed <= elapsed + 32'd1;
          // A match beats exhaustion when both land on the same edge.
          if (win_any) begin
            state            <= ST_FOUND;
            bus.result_key   <= core_keys[win_idx];
            bus.result_core  <= win_idx;
            bus.stop_all     <= 1'b1;
            bus.result_valid <= 1'b1;
            LEDR             <= led_found;
          end else if (all_done) begin
            state            <= ST_FAIL;
            bus.result_key   <= '0;
            bus.result_core  <= '0;
            bus.stop_all     <= 1'b1;
            bus.result_valid <= 1'b1;
            LEDR             <= '0;
            LEDR[LED_FAIL]   <= 1'b1;
          end
        end
        ST_FOUND, ST_FAIL: begin
          // Result fields are left alone on ack so the last answer stays readable.
          if (bus.result_ack) begin
            state            <= ST_IDLE;
            bus.stop_all     <= 1'b0;
            bus.result_valid <= 1'b0;
            LEDR             <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_collector.sv
// Directed bench for key_search_collector: vector table of whole campaigns plus corner sequences.
// Latency: checks sample on the falling edge after each rising edge.
// Backpressure: exercises result_ack hold-off and ignored start/found outside SEARCH.
module tb_key_search_collector;

  logic        CLOCK_50;
  logic        reset_n;
  logic        start;
  logic [31:0] elapsed;
  logic [9:0]  LEDR;

  int total = 0;
  int bad   = 0;

  key_search_collector_if #(.NUM_CORES(4), .KEY_W(24)) bus ();

  key_search_collector #(.NUM_CORES(4), .KEY_W(24)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .elapsed  (elapsed),
    .LEDR     (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          wait_cyc;
    logic [3:0]  found;
    logic [3:0]  done;
    logic [95:0] keys;
    logic [23:0] exp_key;
    logic [1:0]  exp_core;
    logic [9:0]  exp_led;
    int          exp_elapsed;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic clear_cores();
    bus.core_found = '0;
    bus.core_done  = '0;
    bus.core_key   = '0;
  endtask

  task automatic check_result(input string tag, input logic [23:0] key, input logic [1:0] core,
                              input logic [9:0] led, input int el);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_stop"}, 32'(bus.stop_all), 32'd1);
    check({tag, "_key"}, 32'(bus.result_key), 32'(key));
    check({tag, "_core"}, 32'(bus.result_core), 32'(core));
    check({tag, "_led"}, 32'(LEDR), 32'(led));
    check({tag, "_elapsed"}, elapsed, 32'(el));
  endtask

  task automatic ack_and_check(input string tag);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_ack_stop"}, 32'(bus.stop_all), 32'd0);
    check({tag, "_ack_led"}, 32'(LEDR), 32'd0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", n);
    clear_cores();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (v.wait_cyc) tick();
    check({tag, "_search_led"}, 32'(LEDR), 32'h004);
    bus.core_found = v.found;
    bus.core_done  = v.done;
    bus.core_key   = v.keys;
    tick();
    clear_cores();
    check_result(tag, v.exp_key, v.exp_core, v.exp_led, v.exp_elapsed);
    ack_and_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{10, 4'b0100, 4'b0000, {24'h444444, 24'h03FF3D, 24'h222222, 24'h111111},
                24'h03FF3D, 2'd2, 10'b0100000001, 11};
    vecs[1] = '{3, 4'b1010, 4'b0000, {24'h123456, 24'h555555, 24'h0BCDEF, 24'hAAAAAA},
                24'h0BCDEF, 2'd1, 10'b0010000001, 4};
    vecs[2] = '{0, 4'b0001, 4'b1111, {24'h999999, 24'h888888, 24'h777777, 24'h00ABCD},
                24'h00ABCD, 2'd0, 10'b0001000001, 1};
    vecs[3] = '{5, 4'b0000, 4'b1111, {24'h999999, 24'h888888, 24'h777777, 24'h666666},
                24'h000000, 2'd0, 10'b0000000010, 6};
    vecs[4] = '{2, 4'b1000, 4'b0000, {24'hFFFFFF, 24'h000001, 24'h000002, 24'h000003},
                24'hFFFFFF, 2'd3, 10'b1000000001, 3};

    reset_n = 1'b0;
    start = 1'b0;
    bus.result_ack = 1'b0;
    clear_cores();
    #25;
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_stop", 32'(bus.stop_all), 32'd0);
    check("rst_key", 32'(bus.result_key), 32'd0);
    check("rst_core", 32'(bus.result_core), 32'd0);
    check("rst_elapsed", elapsed, 32'd0);
    check("rst_led", 32'(LEDR), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick();

    // Found/done and ack while idle must be ignored.
    bus.core_found = 4'b1111;
    bus.core_done  = 4'b1111;
    bus.result_ack = 1'b1;
    tick();
    tick();
    clear_cores();
    bus.result_ack = 1'b0;
    check("idle_ignore_valid", 32'(bus.result_valid), 32'd0);
    check("idle_ignore_led", 32'(LEDR), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Done pulses on separate cycles accumulate into a failure.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.core_done = 4'(1 << i);
      tick();
    end
    bus.core_done = '0;
    check("seq_fail_pending_valid", 32'(bus.result_valid), 32'd0);
    bus.core_done = 4'b1000;
    tick();
    bus.core_done = '0;
    check_result("seq_fail", 24'h0, 2'd0, 10'b0000000010, 4);
    ack_and_check("seq_fail");

    // Sticky done on three cores, then the last core both finds and finishes.
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.core_done = 4'b0111;
    tick();
    bus.core_done = 4'b0000;
    tick();
    bus.core_found = 4'b1000;
    bus.core_done  = 4'b1000;
    bus.core_key   = {24'h0C0FFE, 24'h0, 24'h0, 24'h0};
    tick();
    clear_cores();
    check_result("seq_sticky", 24'h0C0FFE, 2'd3, 10'b1000000001, 3);
    ack_and_check("seq_sticky");

    // Reset in the middle of a search drops everything without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("seq_rst_pre_elapsed", elapsed, 32'd3);
    #2;
    reset_n = 1'b0;
    #2;
    check("seq_rst_elapsed", elapsed, 32'd0);
    check("seq_rst_led", 32'(LEDR), 32'd0);
    check("seq_rst_key", 32'(bus.result_key), 32'd0);
    check("seq_rst_core", 32'(bus.result_core), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick();
    check("seq_rst_idle_led", 32'(LEDR), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    bus.core_found = 4'b0010;
    bus.core_key   = {24'h0, 24'h0, 24'h0F00F0, 24'h0};
    tick();
    clear_cores();
    check_result("seq_rst_again", 24'h0F00F0, 2'd1, 10'b0010000001, 3);
    ack_and_check("seq_rst_again");

    // Held result: ack withheld, start and core activity must not disturb it.
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.core_found = 4'b0100;
    bus.core_key   = {24'h0, 24'h012345, 24'h0, 24'h0};
    tick();
    for (int i = 0; i < 5; i++) begin
      start          = 1'b1;
      bus.core_found = 4'b0001;
      bus.core_done  = 4'b1111;
      bus.core_key   = {4{24'hBADBAD}};
      tick();
      check_result($sformatf("hold%0d", i), 24'h012345, 2'd2, 10'b0100000001, 1);
    end
    start = 1'b0;
    clear_cores();
    ack_and_check("hold");
    check("hold_key_kept", 32'(bus.result_key), 32'h012345);
    check("hold_core_kept", 32'(bus.result_core), 32'd2);
    tick();
    check("hold_elapsed_frozen", elapsed, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_restart_led", 32'(LEDR), 32'h004);
    check("hold_restart_elapsed", elapsed, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_search_collector.md
KEY_SEARCH_COLLECTOR -- requirements
Module: key_search_collector

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, number of cracker cores observed.
REQ-002 The block SHALL have parameter KEY_W, default 24, width of one candidate key.
REQ-003 Port CLOCK_50  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle pulse that begins a search campaign.
REQ-006 Port core_found  input  NUM_CORES  per-core pulse: key matched this cycle.
REQ-007 Port core_done  input  NUM_CORES  per-core level or pulse: range exhausted without match.
REQ-008 Port core_key  input  NUM_CORES*KEY_W  per-core candidate key, slice i valid when core_found[i]=1.
REQ-009 Port stop_all  output  1  broadcast halt to every core.
REQ-010 Port result_valid  output  1  result available to downstream.
REQ-011 Port result_ack  input  1  downstream accepts result.
REQ-012 Port result_key  output  KEY_W  winning key.
REQ-013 Port result_core  output  $clog2(NUM_CORES)  index of winning core.
REQ-014 Port elapsed  output  32  campaign duration in clock cycles.
REQ-015 Port LEDR  output  10  board status LEDs.

Function
REQ-016 FSM states SHALL be IDLE, SEARCH, FOUND, FAIL.
REQ-017 IDLE -> SEARCH on start=1; sticky done mask and elapsed SHALL clear on that edge.
REQ-018 SEARCH: each cycle, any core_done[i]=1 SHALL set sticky done bit i; elapsed SHALL increment by 1, saturating at 32'hFFFF_FFFF.
REQ-019 SEARCH -> FOUND when any core_found bit=1; lowest-index asserted core SHALL win; its key slice and index SHALL be captured on that edge.
REQ-020 SEARCH -> FAIL when sticky mask OR current core_done is all-ones and no core_found bit is set that cycle.
REQ-021 core_found and final core_done in the same cycle: FOUND SHALL take priority.
REQ-022 stop_all SHALL be 1 in FOUND and FAIL, registered, asserting the cycle after the transition edge.
REQ-023 result_valid SHALL be 1 in FOUND and FAIL; result_key/result_core SHALL hold constant while result_valid=1; in FAIL both SHALL be 0.
REQ-024 result_valid=1 and result_ack=1 on an edge: FSM SHALL return to IDLE; result_key/result_core SHALL retain values; elapsed SHALL freeze.
REQ-025 start while not in IDLE SHALL be ignored; result_ack while result_valid=0 SHALL be ignored.
REQ-026 core_found/core_done outside SEARCH SHALL be ignored.
REQ-027 LEDR[0]=1 in FOUND; LEDR[1]=1 in FAIL; LEDR[2]=1 in SEARCH; LEDR[6+i]=1 for winning core i while FOUND (NUM_CORES=4); all other LEDR bits 0.
REQ-028 All outputs SHALL be registered; stop_all and result_valid SHALL have no combinational path from inputs.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, stop_all=0, result_valid=0, result_key=0, result_core=0, elapsed=0, LEDR=0, sticky mask=0.
REQ-030 Reset asserted mid-SEARCH SHALL abandon the campaign with no result; deassertion SHALL leave the block in IDLE awaiting start.

Structure
REQ-031 Package ksa_pkg SHALL hold the state enum, NUM_CORES and KEY_W defaults, and the LED bit-position constants.
REQ-032 A sub-module core_prio_enc SHALL implement the lowest-index-wins priority encoder (one-hot valid in, index + any out).

Verification
REQ-033 start; after 10 cycles core_found=4'b0100, core_key slice2=24'h03FF3D -> FOUND, result_core=2, result_key=24'h03FF3D, elapsed=11, LEDR=10'b0100000001, stop_all=1 next cycle.
REQ-034 Same cycle core_found=4'b1010 -> result_core=1, key from slice1.
REQ-035 core_done pulsed 0,1,2,3 on separate cycles, no found -> FAIL after pulse 3, result_key=0, LEDR[1]=1.
REQ-036 core_done=4'b0111 sticky, then core_found[3]=1 with core_done[3]=1 same cycle -> FOUND, result_core=3.
REQ-037 reset_n=0 mid-SEARCH -> all outputs 0 asynchronously; second start after reset runs a clean campaign with elapsed restarting at 0.
REQ-038 In FOUND, hold result_ack=0 for 5 cycles -> outputs stable; ack=1 -> IDLE next cycle, result_valid=0, start accepted again.
